// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with a registered read port.
// Pushes become RAM writes at a wrapping write pointer; RAM words are
// prefetched into a 2-entry output buffer so the pop side runs at one word
// per cycle. Occupancy is tracked in a single counter from which the
// full/empty/almost_full flags are decoded.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_THRESH  = 240
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic                  readEnable,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] dataOut,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   C_AF      = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_inflight;
    logic [1:0]            r_ob_count;
    logic [DATA_WIDTH-1:0] r_ob_head;
    logic [DATA_WIDTH-1:0] r_ob_tail;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_ob_occ;

    // Handshakes and read-issue decision, all from registered state.
    // Push is also qualified by reset_n so no RAM write escapes during reset.
    always_comb begin
        in_ready  = (r_count < C_DEPTH);
        out_valid = (r_ob_count != 2'd0);
        w_push    = in_valid && in_ready && reset_n;
        w_pop     = out_valid && out_ready;
        w_ob_occ  = {1'b0, r_ob_count} + {2'b00, r_inflight};
        // Buffered plus in-flight words, minus this cycle's pop, must leave a free slot.
        w_issue   = (r_ram_count != '0) && (w_ob_occ < (3'd2 + {2'b00, w_pop}));
    end

    // RAM port drive and status decode.
    always_comb begin
        writeEnable  = w_push;
        dataIn       = w_push ? in_data : '0;
        writeAddress = r_wr_ptr;
        readEnable   = w_issue;
        readAddress  = r_rd_ptr;
        out_data     = out_valid ? r_ob_head : '0;
        count        = r_count;
        full         = (r_count == C_DEPTH);
        empty        = (r_count == '0);
        almost_full  = (r_count >= C_AF);
    end

    // Wrapping RAM pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_issue) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Total occupancy and words resident in RAM awaiting a read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_ram_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            case ({w_push, w_issue})
                2'b10:   r_ram_count <= r_ram_count + C_CNT_ONE;
                2'b01:   r_ram_count <= r_ram_count - C_CNT_ONE;
                default: r_ram_count <= r_ram_count;
            endcase
        end
    end

    // Output buffer: head/tail pair filled from dataOut the cycle after a read issue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_ob_count <= 2'd0;
            r_ob_head  <= '0;
            r_ob_tail  <= '0;
        end else begin
            r_inflight <= w_issue;
            case ({r_inflight, w_pop})
                2'b01: begin
                    r_ob_count <= r_ob_count - 2'd1;
                    r_ob_head  <= r_ob_tail;
                end
                2'b10: begin
                    r_ob_count <= r_ob_count + 2'd1;
                    if (r_ob_count == 2'd0) r_ob_head <= dataOut;
                    else                    r_ob_tail <= dataOut;
                end
                2'b11: begin
                    // Simultaneous capture and pop: the new word lands one slot closer to the head.
                    if (r_ob_count == 2'd1) begin
                        r_ob_head <= dataOut;
                    end else begin
                        r_ob_head <= r_ob_tail;
                        r_ob_tail <= dataOut;
                    end
                end
                default: r_ob_count <= r_ob_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Testbench for dpram_fifo_ctrl: directed scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based FIFO model and a simple RAM.
module tb_dpram_fifo_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       writeEnable;
    logic [7:0] dataIn;
    logic [7:0] writeAddress;
    logic       readEnable;
    logic [7:0] readAddress;
    logic [7:0] dataOut = 8'h00;
    logic [8:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;

    dpram_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .AF_THRESH (240)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .writeEnable (writeEnable),
        .dataIn      (dataIn),
        .writeAddress(writeAddress),
        .readEnable  (readEnable),
        .readAddress (readAddress),
        .dataOut     (dataOut),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    always #5 clock = ~clock;

    // RAM with a registered read port; contents survive reset.
    logic [7:0] mem [0:255];
    always @(posedge clock) begin
        if (writeEnable) mem[writeAddress] <= dataIn;
        if (readEnable)  dataOut <= mem[readAddress];
    end

    // Reference model
    logic [7:0]  model_q[$];
    int unsigned wr_cnt, rd_cnt, pop_cnt;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Per-cycle observations for directed checks
    logic       last_we, last_re, last_ov, last_inr, last_full, last_af, last_pop;
    logic [7:0] last_wa, last_ra, last_od;
    logic [8:0] last_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        wr_cnt  = 0;
        rd_cnt  = 0;
        pop_cnt = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int unsigned sz;
        logic        m_push, m_pop, m_rd;
        logic [7:0]  m_data;
        @(negedge clock);
        sz     = model_q.size();
        m_push = in_valid && (sz < 256);
        m_pop  = out_valid && out_ready && (sz > 0);
        m_rd   = readEnable;
        m_data = in_data;
        chk("count",    32'(count),       32'(sz));
        chk("empty",    32'(empty),       32'(sz == 0));
        chk("full",     32'(full),        32'(sz == 256));
        chk("afull",    32'(almost_full), 32'(sz >= 240));
        chk("in_ready", 32'(in_ready),    32'(sz < 256));
        chk("wr_en",    32'(writeEnable), 32'(m_push));
        if (m_push) begin
            chk("wr_addr", 32'(writeAddress), wr_cnt % 256);
            chk("wr_data", 32'(dataIn),       32'(in_data));
        end
        if (readEnable) begin
            chk("rd_addr",  32'(readAddress), rd_cnt % 256);
            chk("rd_ahead", 32'(rd_cnt < wr_cnt), 32'd1);
        end
        if (out_valid) begin
            chk("ov_nonempty", 32'(sz > 0), 32'd1);
            if (sz > 0) chk("out_data", 32'(out_data), 32'(model_q[0]));
        end else begin
            chk("out_data_idle", 32'(out_data), 32'd0);
        end
        chk("outstanding", 32'((rd_cnt - pop_cnt) <= 2), 32'd1);
        chk("invariant", 32'(dut.r_count),
            32'(dut.r_ram_count) + 32'(dut.r_inflight) + 32'(dut.r_ob_count));
        last_we = writeEnable; last_re = readEnable; last_ov = out_valid;
        last_inr = in_ready; last_full = full; last_af = almost_full;
        last_wa = writeAddress; last_ra = readAddress; last_od = out_data;
        last_count = count; last_pop = m_pop;
        @(posedge clock);
        if (m_rd) rd_cnt++;
        if (m_pop) begin
            void'(model_q.pop_front());
            pop_cnt++;
        end
        if (m_push) begin
            model_q.push_back(m_data);
            wr_cnt++;
        end
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready),     32'd1);
        chk("rst_out_valid",32'(out_valid),    32'd0);
        chk("rst_out_data", 32'(out_data),     32'd0);
        chk("rst_we",       32'(writeEnable),  32'd0);
        chk("rst_re",       32'(readEnable),   32'd0);
        chk("rst_waddr",    32'(writeAddress), 32'd0);
        chk("rst_raddr",    32'(readAddress),  32'd0);
        chk("rst_datain",   32'(dataIn),       32'd0);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_afull",    32'(almost_full),  32'd0);
        chk("rst_empty",    32'(empty),        32'd1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        check_reset_vals();
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain(input int unsigned limit);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int unsigned i = 0; i < limit && model_q.size() > 0; i++) cycle();
        chk("drain_left", model_q.size(), 32'd0);
        cycle();
    endtask

    initial begin
        int unsigned n, pops, p_in, p_out;

        // Latency of a single word through an empty FIFO
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        cycle();
        chk("lat_we0",    32'(last_we), 32'd1);
        chk("lat_waddr0", 32'(last_wa), 32'd0);
        in_valid = 1'b0;
        cycle();
        chk("lat_re1",    32'(last_re), 32'd1);
        chk("lat_raddr1", 32'(last_ra), 32'd0);
        cycle();
        chk("lat_ov2",    32'(last_ov), 32'd0);
        cycle();
        chk("lat_ov3",    32'(last_ov), 32'd1);
        chk("lat_od3",    32'(last_od), 32'h11);
        cycle();
        chk("lat_empty",  32'(empty),   32'd1);

        // Fill to full, drop an extra push, pop at full, then drain in order
        do_reset();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cycle();
            if (i == 239) chk("af_below", 32'(last_af), 32'd0);
        end
        chk("af_at_full", 32'(almost_full), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        cycle();
        chk("full_flag",  32'(last_full), 32'd1);
        chk("full_inr",   32'(last_inr),  32'd0);
        chk("full_drop",  32'(last_we),   32'd0);
        out_ready = 1'b1;
        cycle();
        chk("fullpop_pop", 32'(last_pop), 32'd1);
        chk("fullpop_we",  32'(last_we),  32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("fullpop_count", 32'(last_count), 32'd255);
        chk("fullpop_inr",   32'(last_inr),   32'd1);
        drain(400);

        // Continuous streaming across two pointer wraps
        do_reset();
        out_ready = 1'b1;
        n = 0;
        pops = 0;
        for (int unsigned c = 0; c < 700 && n < 600; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(n);
            cycle();
            if (last_we)  n++;
            if (last_pop) pops++;
        end
        chk("stream_pushed", n, 32'd600);
        chk("stream_rate", 32'(pops >= 595), 32'd1);
        drain(50);

        // Head held under backpressure
        do_reset();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h5A + 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        for (int unsigned i = 0; i < 5; i++) begin
            cycle();
            chk("hold_ov", 32'(last_ov), 32'd1);
            chk("hold_od", 32'(last_od), 32'h5A);
        end
        drain(20);

        // Reset between read issue and returning RAM data
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("mid_re", 32'(last_re), 32'd1);
        reset_n = 1'b0;
        model_clear();
        #1;
        check_reset_vals();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            cycle();
            chk("stale_ov", 32'(last_ov), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 8'h33;
        cycle();
        chk("post_waddr", 32'(last_wa), 32'd0);
        in_valid = 1'b0;
        cycle();
        chk("post_re",    32'(last_re), 32'd1);
        chk("post_raddr", 32'(last_ra), 32'd0);
        drain(20);

        // Randomized traffic with shifting push/pop bias
        do_reset();
        p_in  = 50;
        p_out = 50;
        for (int unsigned c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                p_in  = $urandom_range(95, 10);
                p_out = $urandom_range(95, 5);
            end
            in_valid  = ($urandom % 100) < p_in;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 100) < p_out;
            cycle();
        end
        drain(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
